bit_serializer: RTL



---
 rtl/bit_serializer.sv | 85 ++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// LSB-first word serializer with a valid/ready bit handshake and a running
// count of accepted '1' bits; done holds until start is seen low.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       bit_ready,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic [$clog2(WIDTH+1)-1:0] ones_sent,
  output logic                       done,
  output logic [1:0]                 state_dbg
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [IW-1:0]    bit_idx, idx_next;
  logic [CW-1:0]    ones_cnt, ones_next;

  // Handshake: a bit transfers on a rising edge where bit_valid and bit_ready
  // are both 1; bit_valid never drops and bit_out never changes until then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      ones_cnt  <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_idx   <= idx_next;
      ones_cnt  <= ones_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    idx_next   = bit_idx;
    ones_next  = ones_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          shift_next = load_data;
          idx_next   = '0;
          ones_next  = '0;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_ready) begin
          shift_next = shift_reg >> 1;
          idx_next   = bit_idx + IW'(1);
          ones_next  = ones_cnt + CW'(shift_reg[0]);
          // The shifted-out register is all zeros by the last bit, so it
          // also keeps bit_out low while idle or done.
          if (bit_idx == IW'(WIDTH-1)) state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bit_valid = (state == S_SHIFT);
  assign bit_out   = bit_valid & shift_reg[0];
  assign done      = (state == S_DONE);
  assign ones_sent = ones_cnt;
  assign state_dbg = state;

endmodule
